// File: rtl/enable_gen_multi.sv
// -----------------------------------------------------------------------------
// enable_gen_multi
//
// Multi-rate clock-enable generator. A three-stage cascaded prescaler derives
// three one-cycle enable strobes from CLK, plus a half-second blink level:
//
//   stage 0  pre_cnt  0..PRE_MAX  -> EN_BASE  at BASE_HZ
//   stage 1  mid_cnt  0..DIV1-1   -> EN_SCAN  at BASE_HZ/DIV1
//   stage 2  sec_cnt  0..DIV2-1   -> EN_SEC   at BASE_HZ/(DIV1*DIV2)
//                                 -> BLINK    0 in first half of the second,
//                                             1 in the second half
//
// Run/stop, synchronous clear, single-step (while stopped) and a fast demo
// mode (EN_SEC follows EN_SCAN) are layered on top. These strobes feed the
// CNT60 counters, the display scanner and the colon blinker.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz
//   BASE_HZ   base tick rate; CLK_FREQ/BASE_HZ must be an integer >= 2
//   DIV1      base ticks per scan tick (>= 2)
//   DIV2      scan ticks per second tick (>= 2, even)
//   PRE_W     prescaler width; must hold CLK_FREQ/BASE_HZ-1
//   MID_W     stage-1 counter width; must hold DIV1-1
//   SEC_W     stage-2 counter width; must hold DIV2-1
//
// Ports
//   CLK      in   system clock
//   RESET    in   asynchronous, active-high reset
//   RUN      in   1 = counters advance, 0 = counters frozen
//   CLR      in   synchronous clear of all counters and outputs
//   FAST     in   1 = EN_SEC pulses at scan rate
//   STEP     in   debounced, synchronous level; a rising edge while stopped
//                 produces one EN_SEC
//   EN_BASE  out  one-cycle strobe at BASE_HZ
//   EN_SCAN  out  one-cycle strobe at BASE_HZ/DIV1
//   EN_SEC   out  one-cycle strobe at BASE_HZ/(DIV1*DIV2), or per FAST/STEP
//   BLINK    out  half-second blink level
// -----------------------------------------------------------------------------
module enable_gen_multi #(
    parameter int CLK_FREQ = 12000000,
    parameter int BASE_HZ  = 1000,
    parameter int DIV1     = 10,
    parameter int DIV2     = 100,
    parameter int PRE_W    = 24,
    parameter int MID_W    = 8,
    parameter int SEC_W    = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RUN,
    input  logic CLR,
    input  logic FAST,
    input  logic STEP,
    output logic EN_BASE,
    output logic EN_SCAN,
    output logic EN_SEC,
    output logic BLINK
);

    // Terminal counts of each stage, sized to the counter they are compared with.
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_FREQ / BASE_HZ - 1);
    localparam logic [MID_W-1:0] MID_MAX  = MID_W'(DIV1 - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(DIV2 - 1);
    localparam logic [SEC_W-1:0] SEC_HALF = SEC_W'(DIV2 / 2);

    logic [PRE_W-1:0] pre_cnt;
    logic [MID_W-1:0] mid_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic             step_q;     // previous STEP sample for edge detection

    logic             base_tick;  // stage 0 wraps on this edge
    logic             scan_tick;  // stage 1 wraps on this edge
    logic             sec_tick;   // stage 2 wraps on this edge
    logic             step_edge;
    logic             sec_req;    // EN_SEC wanted on the next cycle
    logic [SEC_W-1:0] sec_next;

    // Tick decode. Each stage only looks at its own count and the tick of the
    // stage below, so coincident strobes come out of the same edge and stay
    // aligned in the registered outputs.
    // NOTE: every always_comb output gets a value on every path (defaults
    // first); a missed branch would otherwise infer a latch.
    always_comb begin
        base_tick = 1'b0;
        scan_tick = 1'b0;
        sec_tick  = 1'b0;
        sec_req   = 1'b0;
        sec_next  = sec_cnt;

        base_tick = RUN && (pre_cnt == PRE_MAX);
        scan_tick = base_tick && (mid_cnt == MID_MAX);
        sec_tick  = scan_tick && (sec_cnt == SEC_MAX);
        step_edge = STEP && !step_q;

        if (scan_tick) begin
            sec_next = sec_tick ? '0 : sec_cnt + SEC_W'(1);
        end

        // FAST swaps the source of EN_SEC only; sec_cnt and BLINK still count
        // real seconds. A STEP edge only counts while stopped, when no tick
        // can be pending, so it never competes with a counter-generated pulse.
        sec_req = FAST ? scan_tick : sec_tick;
        if (!RUN && step_edge) begin
            sec_req = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order in this block.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_cnt <= '0;
            mid_cnt <= '0;
            sec_cnt <= '0;
            step_q  <= 1'b0;
            EN_BASE <= 1'b0;
            EN_SCAN <= 1'b0;
            EN_SEC  <= 1'b0;
            BLINK   <= 1'b0;
        end else if (CLR) begin
            pre_cnt <= '0;
            mid_cnt <= '0;
            sec_cnt <= '0;
            // Track STEP even while clearing, so an edge arriving together
            // with CLR is swallowed rather than firing once CLR drops.
            step_q  <= STEP;
            EN_BASE <= 1'b0;
            EN_SCAN <= 1'b0;
            EN_SEC  <= 1'b0;
            BLINK   <= 1'b0;
        end else begin
            step_q  <= STEP;
            EN_BASE <= base_tick;
            EN_SCAN <= scan_tick;
            // Belt-and-braces: a STEP pulse immediately followed by RUN and a
            // tick could otherwise give EN_SEC two cycles in a row.
            EN_SEC  <= sec_req && !EN_SEC;

            // Stopping simply freezes the counts; resuming continues from
            // the held phase.
            if (RUN) begin
                pre_cnt <= base_tick ? '0 : pre_cnt + PRE_W'(1);
            end

            if (base_tick) begin
                mid_cnt <= scan_tick ? '0 : mid_cnt + MID_W'(1);
            end

            // BLINK is derived from the post-tick count so it changes in the
            // same cycle as the EN_SCAN that moves sec_cnt across the midpoint.
            if (scan_tick) begin
                sec_cnt <= sec_next;
                BLINK   <= (sec_next >= SEC_HALF);
            end
        end
    end

endmodule
